data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed data memory responder: one request at a time, IDLE -> ACCESS -> RESP.
// Optional macro DMEM_MISALIGN_TRAP_EN: fault misaligned half/word accesses instead of aligning down.
module data_mem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic        clk1,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_nxt;

  logic              we_p0;
  logic [2:0]        f3_p0;
  logic [31:0]       addr_p0;
  logic [31:0]       wdata_p0;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              size_ok_p1;
  logic              range_ok_p1;
  logic              err_p1;
  logic              wr_en_p1;
  logic [1:0]        lane_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic [31:0]       word_p1;
  logic [31:0]       merged_p1;
  logic [31:0]       load_p1;

  // Right-align the addressed lane and extend according to funct3.
  function automatic logic [31:0] load_ext(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] r;
    sh = word >> {lane, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (f3)
      3'b000:  r = b;
      3'b001:  r = h;
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  lane);
    logic [31:0] rep;
    logic [3:0]  be;
    logic [31:0] res;
    case (sz)
      2'b00: begin
        rep = {4{wdata[7:0]}};
        be  = 4'b0001 << lane;
      end
      2'b01: begin
        rep = {2{wdata[15:0]}};
        be  = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        rep = wdata;
        be  = 4'b1111;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? rep[8*i +: 8] : word[8*i +: 8];
    end
    return res;
  endfunction

  assign req_ready = (state == IDLE) && rst_n;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Stage p0: request capture on acceptance
  always_ff @(posedge clk1) begin
    if (accept) begin
      we_p0    <= req_we;
      f3_p0    <= req_funct3;
      addr_p0  <= req_addr;
      wdata_p0 <= req_wdata;
    end
  end

  // Stage p1: decode, fault checks and array access during ACCESS
  always_comb begin
    size_ok_p1 = 1'b0;
    case (f3_p0)
      3'b000, 3'b001, 3'b010: size_ok_p1 = 1'b1;
      3'b100, 3'b101:         size_ok_p1 = !we_p0;
      default:                size_ok_p1 = 1'b0;
    endcase
    range_ok_p1 = {2'b00, addr_p0[31:2]} < 32'(DEPTH);
    err_p1      = !size_ok_p1 || !range_ok_p1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((f3_p0[1:0] == 2'b01 && addr_p0[0]) ||
        (f3_p0[1:0] == 2'b10 && addr_p0[1:0] != 2'b00))
      err_p1 = 1'b1;
`endif
    case (f3_p0[1:0])
      2'b01:   lane_p1 = {addr_p0[1], 1'b0};
      2'b10:   lane_p1 = 2'b00;
      default: lane_p1 = addr_p0[1:0];
    endcase
    idx_p1    = range_ok_p1 ? addr_p0[IDX_W+1:2] : '0;
    word_p1   = mem[idx_p1];
    merged_p1 = store_merge(word_p1, wdata_p0, f3_p0[1:0], lane_p1);
    load_p1   = load_ext(word_p1, f3_p0, lane_p1);
    wr_en_p1  = we_p0 && !err_p1;
  end

  always_ff @(posedge clk1) begin
    if (rst_n && state == ACCESS && wr_en_p1) mem[idx_p1] <= merged_p1;
  end

  // Stage p2: response registers, held through RESP
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (state == ACCESS) begin
      rsp_err   <= err_p1;
      rsp_rdata <= (err_p1 || we_p0) ? 32'd0 : load_p1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder against a byte-array reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]  mb [4*DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk1 = ~clk1;

  data_mem_responder #(.DEPTH(DEPTH)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, loads assembled and extended arithmetically.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int sz;
    longint unsigned a, v;
    er = 1'b0;
    rd = 32'd0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default: begin sz = 0; er = 1'b1; end
    endcase
    if (we && f3 >= 3'd4) er = 1'b1;
    if (addr / 4 >= DEPTH) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (sz > 1 && (addr % sz) != 0) er = 1'b1;
`endif
    if (er) return;
    a = addr - (addr % sz);
    if (we) begin
      for (int i = 0; i < sz; i++) mb[a+i] = 8'(wdata >> (8*i));
    end else begin
      v = 0;
      for (int i = 0; i < sz; i++) v += longint'(mb[a+i]) << (8*i);
      if (f3 < 3'd4 && v >= (64'd1 << (8*sz-1))) v = v + (64'd1 << 32) - (64'd1 << (8*sz));
      rd = 32'(v);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int stall,
                        input logic [31:0] exp_rd, input logic exp_er);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk1); #1;
    // keep a scrambled request pending: it must not be taken while busy
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'(4 * $urandom_range(0, 15));
    req_wdata  = $urandom;
    chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("access_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk1); #1;
    chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("resp_rdata", rsp_rdata, exp_rd);
    chk("resp_err", 32'(rsp_err), 32'(exp_er));
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk1); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, exp_rd);
      chk("stall_err", 32'(rsp_err), 32'(exp_er));
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk1); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("done_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("done_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int stall);
    logic [31:0] erd;
    logic        eer;
    model(we, f3, addr, wdata, erd, eer);
    do_req(we, f3, addr, wdata, stall, erd, eer);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;

    repeat (3) @(posedge clk1);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);

    for (int w = 0; w < 16; w++) run(1'b1, 3'd2, 32'(4*w), $urandom, 0);

    run(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0);
    chk("sw_rdata_zero", last_rdata, 32'd0);
    run(1'b0, 3'd2, 32'h10, 32'd0, 0);
    chk("lw_deadbeef", last_rdata, 32'hDEADBEEF);
    chk("lw_deadbeef_err", 32'(last_err), 32'd0);

    run(1'b1, 3'd0, 32'h11, 32'h00000080, 0);
    run(1'b0, 3'd0, 32'h11, 32'd0, 0);
    chk("lb_sext", last_rdata, 32'hFFFFFF80);
    run(1'b0, 3'd4, 32'h11, 32'd0, 0);
    chk("lbu_zext", last_rdata, 32'h00000080);
    run(1'b0, 3'd2, 32'h10, 32'd0, 0);
    chk("lw_after_sb", last_rdata, 32'hDEAD80EF);

    run(1'b0, 3'd1, 32'h12, 32'd0, 0);
    chk("lh_0x12", last_rdata, 32'hFFFFDEAD);
    chk("lh_0x12_err", 32'(last_err), 32'd0);
    run(1'b0, 3'd1, 32'h13, 32'd0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lh_0x13_trap_err", 32'(last_err), 32'd1);
    chk("lh_0x13_trap_rdata", last_rdata, 32'd0);
`else
    chk("lh_0x13_aligned", last_rdata, 32'hFFFFDEAD);
    chk("lh_0x13_err", 32'(last_err), 32'd0);
`endif

    run(1'b1, 3'd2, 32'h1000, 32'hCAFEF00D, 0);
    chk("sw_oob_err", 32'(last_err), 32'd1);
    run(1'b0, 3'd2, 32'h0, 32'd0, 0);
    run(1'b1, 3'd4, 32'h4, 32'h55, 0);
    chk("sbu_err", 32'(last_err), 32'd1);
    run(1'b0, 3'd3, 32'h4, 32'd0, 0);
    chk("f3_011_err", 32'(last_err), 32'd1);

    run(1'b0, 3'd2, 32'h10, 32'd0, 5);
    chk("stall_lw", last_rdata, 32'hDEAD80EF);

    // reset while a store sits in ACCESS: the store must be lost
    chk("rst_acc_req_ready", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h20;
    req_wdata  = 32'h12345678;
    @(posedge clk1); #1;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk1); #1;
    chk("rst_acc_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_acc_rdata", rsp_rdata, 32'd0);
    chk("rst_acc_req_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_acc_idle", 32'(req_ready), 32'd1);
    run(1'b0, 3'd2, 32'h20, 32'd0, 0);

    for (int t = 0; t < 200; t++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = $urandom | 32'h0000_1000;
      else                           a = 32'($urandom_range(0, 63));
      run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
          int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
